// File: rtl/zood_pkg.sv
// Shared definitions for the Zood game blocks (master-code loader and guess grader).
// Holds the default game geometry, the shape type, the empty-shape code and the
// grader state encoding.
package zood_pkg;

  localparam int DEFAULT_NUM_SLOTS  = 4;
  localparam int DEFAULT_SHAPE_W    = 3;
  localparam int DEFAULT_MAX_ROUNDS = 8;

  typedef logic [DEFAULT_SHAPE_W-1:0] shape_t;

  // Shape code 0 marks an empty slot.
  localparam shape_t EMPTY_SHAPE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXACT,
    ST_PARTIAL,
    ST_DONE
  } grader_state_t;

endpackage

// File: rtl/guess_grader.sv
// guess_grader: grades a guess against the loaded master code.
//   znarly = right shape in the right slot, zood = right shape in a wrong slot.
//   Tracks rounds, win/lose and the gamePlaying flag used by the loader.
//   The scan is sequential (one compare per clock) with fixed latency:
//   1 load edge, NUM_SLOTS exact edges, NUM_SLOTS^2 partial edges, then DONE.
// Ports:
//   CLOCK_50, reset_L     clock (rising edge) and async active-low reset
//   newGame               synchronous clear of rounds/flags/counts, aborts a grade
//   masterLoaded          master code is complete
//   master, guess         packed slots, slot i = [i*SHAPE_W +: SHAPE_W]
//   start                 grade request, level sampled in IDLE
//   busy                  grade in progress (LOAD..DONE)
//   gradeValid, badGuess  one-cycle pulses
//   znarly, zood          result counts, held until the next completed grade
//   roundCount, gameWon, gameOver, gamePlaying   game status
module guess_grader
  import zood_pkg::*;
#(
  parameter int NUM_SLOTS  = DEFAULT_NUM_SLOTS,
  parameter int SHAPE_W    = DEFAULT_SHAPE_W,
  parameter int MAX_ROUNDS = DEFAULT_MAX_ROUNDS
) (
  input  logic                                  CLOCK_50,
  input  logic                                  reset_L,
  input  logic                                  newGame,
  input  logic                                  masterLoaded,
  input  logic [NUM_SLOTS*SHAPE_W-1:0]          master,
  input  logic [NUM_SLOTS*SHAPE_W-1:0]          guess,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  gradeValid,
  output logic                                  badGuess,
  output logic [$clog2(NUM_SLOTS+1)-1:0]        znarly,
  output logic [$clog2(NUM_SLOTS+1)-1:0]        zood,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]       roundCount,
  output logic                                  gameWon,
  output logic                                  gameOver,
  output logic                                  gamePlaying
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int RW = $clog2(MAX_ROUNDS + 1);
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  grader_state_t state;

  logic [SHAPE_W-1:0] master_slot [NUM_SLOTS];
  logic [SHAPE_W-1:0] guess_slot  [NUM_SLOTS];
  logic [SHAPE_W-1:0] m_copy      [NUM_SLOTS];
  logic [SHAPE_W-1:0] g_copy      [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] g_mark;
  logic [NUM_SLOTS-1:0] m_mark;
  logic [IW-1:0] ei, pi, pj;
  logic [CW-1:0] znarly_cnt, zood_cnt;

  logic guess_has_empty;
  logic can_play;
  logic hit;
  logic won_now;
  logic last_round;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_unpack
      assign master_slot[gi] = master[gi*SHAPE_W +: SHAPE_W];
      assign guess_slot[gi]  = guess[gi*SHAPE_W +: SHAPE_W];
    end
  endgenerate

  always_comb begin
    guess_has_empty = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (guess_slot[i] == SHAPE_W'(EMPTY_SHAPE)) guess_has_empty = 1'b1;
    end
  end

  // Acceptance uses the live gameOver register, not the registered gamePlaying
  // output, so a finished game can never take one extra grade.
  assign can_play = masterLoaded & ~gameOver;

  // Partial-match candidate: neither side already credited and shapes equal.
  assign hit = ~g_mark[pi] & ~m_mark[pj] & (g_copy[pi] == m_copy[pj]);

  assign won_now    = gameWon | (znarly_cnt == CW'(NUM_SLOTS));
  assign last_round = (roundCount + RW'(1)) == RW'(MAX_ROUNDS);

  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      gradeValid <= 1'b0;
      badGuess   <= 1'b0;
      znarly     <= '0;
      zood       <= '0;
      roundCount <= '0;
      gameWon    <= 1'b0;
      gameOver   <= 1'b0;
      g_mark     <= '0;
      m_mark     <= '0;
      ei         <= '0;
      pi         <= '0;
      pj         <= '0;
      znarly_cnt <= '0;
      zood_cnt   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        m_copy[i] <= '0;
        g_copy[i] <= '0;
      end
    end else begin
      gradeValid <= 1'b0;
      badGuess   <= 1'b0;
      if (newGame) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        znarly     <= '0;
        zood       <= '0;
        roundCount <= '0;
        gameWon    <= 1'b0;
        gameOver   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && can_play) begin
              if (guess_has_empty) begin
                badGuess <= 1'b1;
              end else begin
                // Snapshot here so the grade is immune to later input changes.
                for (int i = 0; i < NUM_SLOTS; i++) begin
                  m_copy[i] <= master_slot[i];
                  g_copy[i] <= guess_slot[i];
                end
                busy  <= 1'b1;
                state <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            g_mark     <= '0;
            m_mark     <= '0;
            znarly_cnt <= '0;
            zood_cnt   <= '0;
            ei         <= '0;
            state      <= ST_EXACT;
          end
          ST_EXACT: begin
            if (g_copy[ei] == m_copy[ei]) begin
              znarly_cnt <= znarly_cnt + CW'(1);
              g_mark[ei] <= 1'b1;
              m_mark[ei] <= 1'b1;
            end
            if (ei == IW'(NUM_SLOTS - 1)) begin
              pi    <= '0;
              pj    <= '0;
              state <= ST_PARTIAL;
            end else begin
              ei <= ei + IW'(1);
            end
          end
          ST_PARTIAL: begin
            if (hit) begin
              zood_cnt   <= zood_cnt + CW'(1);
              g_mark[pi] <= 1'b1;
              m_mark[pj] <= 1'b1;
            end
            if (pj == IW'(NUM_SLOTS - 1)) begin
              pj <= '0;
              if (pi == IW'(NUM_SLOTS - 1)) begin
                // Last compare: publish including this step's hit.
                state      <= ST_DONE;
                gradeValid <= 1'b1;
                znarly     <= znarly_cnt;
                zood       <= zood_cnt + CW'(hit);
                if (roundCount != RW'(MAX_ROUNDS)) roundCount <= roundCount + RW'(1);
                gameWon    <= won_now;
                gameOver   <= gameOver | won_now | last_round;
              end else begin
                pi <= pi + IW'(1);
              end
            end else begin
              pj <= pj + IW'(1);
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) gamePlaying <= 1'b0;
    else          gamePlaying <= can_play;
  end

endmodule
